// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin arbiter that shares one single-port data
// memory between M0 (core LSU) and M1 (DMA/debug). Byte-enabled partial
// stores become a read-modify-write: the old word is read in the grant cycle
// and the merged word is written in a single RMW cycle. Responses come back
// registered, one cycle after the access completes.
module data_mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // master 0 (core LSU)
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_be,
    output logic                  m0_gnt,
    output logic                  m0_rsp_vld,
    output logic [DATA_W-1:0]     m0_rdata,
    // master 1 (DMA / debug)
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_be,
    output logic                  m1_gnt,
    output logic                  m1_rsp_vld,
    output logic [DATA_W-1:0]     m1_rdata,
    // single-port memory
    output logic                  mem_wen,
    output logic [ADDR_W-1:0]     mem_waddr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_ren,
    output logic [ADDR_W-1:0]     mem_raddr,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RMW  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic                prio_q, prio_d;          // 0 = M0 has priority, 1 = M1
    logic                rmw_master_q, rmw_master_d;
    logic [ADDR_W-1:0]   rmw_addr_q, rmw_addr_d;
    logic [DATA_W-1:0]   rmw_wdata_q, rmw_wdata_d;
    logic [BE_W-1:0]     rmw_be_q, rmw_be_d;
    logic [DATA_W-1:0]   rmw_old_q, rmw_old_d;
    logic [DATA_W-1:0]   rmw_merged;

    logic                m0_rsp_vld_q, m1_rsp_vld_q;
    logic [DATA_W-1:0]   m0_rdata_q, m1_rdata_q;
    logic                rsp0_d, rsp1_d;
    logic                load0_d, load1_d;

    // Request selected by the arbiter (only meaningful when someone requests)
    logic                sel_m1;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [BE_W-1:0]     sel_be;

    assign sel_m1    = m1_req && (!m0_req || prio_q);
    assign sel_we    = sel_m1 ? m1_we    : m0_we;
    assign sel_addr  = sel_m1 ? m1_addr  : m0_addr;
    assign sel_wdata = sel_m1 ? m1_wdata : m0_wdata;
    assign sel_be    = sel_m1 ? m1_be    : m0_be;

    // Byte merge for the RMW write: enabled bytes from the store, rest from old word
    generate
        for (genvar gi = 0; gi < BE_W; gi++) begin : g_merge
            assign rmw_merged[gi*8 +: 8] = rmw_be_q[gi] ? rmw_wdata_q[gi*8 +: 8]
                                                        : rmw_old_q[gi*8 +: 8];
        end
    endgenerate

    // Arbitration, memory port drive and next-state; everything quiet while in reset
    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        rmw_master_d = rmw_master_q;
        rmw_addr_d   = rmw_addr_q;
        rmw_wdata_d  = rmw_wdata_q;
        rmw_be_d     = rmw_be_q;
        rmw_old_d    = rmw_old_q;
        m0_gnt       = 1'b0;
        m1_gnt       = 1'b0;
        mem_wen      = 1'b0;
        mem_waddr    = '0;
        mem_wdata    = '0;
        mem_ren      = 1'b0;
        mem_raddr    = '0;
        rsp0_d       = 1'b0;
        rsp1_d       = 1'b0;
        load0_d      = 1'b0;
        load1_d      = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (m0_req || m1_req) begin
                        m0_gnt = !sel_m1;
                        m1_gnt = sel_m1;
                        prio_d = !sel_m1;
                        if (!sel_we) begin
                            mem_ren   = 1'b1;
                            mem_raddr = sel_addr;
                            load0_d   = !sel_m1;
                            load1_d   = sel_m1;
                            rsp0_d    = !sel_m1;
                            rsp1_d    = sel_m1;
                        end else if (sel_be == '1) begin
                            mem_wen   = 1'b1;
                            mem_waddr = sel_addr;
                            mem_wdata = sel_wdata;
                            rsp0_d    = !sel_m1;
                            rsp1_d    = sel_m1;
                        end else if (sel_be == '0) begin
                            rsp0_d    = !sel_m1;
                            rsp1_d    = sel_m1;
                        end else begin
                            // partial store: fetch old word now, write merged word next cycle
                            mem_ren      = 1'b1;
                            mem_raddr    = sel_addr;
                            rmw_master_d = sel_m1;
                            rmw_addr_d   = sel_addr;
                            rmw_wdata_d  = sel_wdata;
                            rmw_be_d     = sel_be;
                            rmw_old_d    = mem_rdata;
                            state_d      = ST_RMW;
                        end
                    end
                end
                ST_RMW: begin
                    mem_wen   = 1'b1;
                    mem_waddr = rmw_addr_q;
                    mem_wdata = rmw_merged;
                    rsp0_d    = !rmw_master_q;
                    rsp1_d    = rmw_master_q;
                    state_d   = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state, round-robin pointer and latched RMW context
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            prio_q       <= 1'b0;
            rmw_master_q <= 1'b0;
            rmw_addr_q   <= '0;
            rmw_wdata_q  <= '0;
            rmw_be_q     <= '0;
            rmw_old_q    <= '0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            rmw_master_q <= rmw_master_d;
            rmw_addr_q   <= rmw_addr_d;
            rmw_wdata_q  <= rmw_wdata_d;
            rmw_be_q     <= rmw_be_d;
            rmw_old_q    <= rmw_old_d;
        end
    end

    // Registered responses; read data only changes on a completed load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_rsp_vld_q <= 1'b0;
            m1_rsp_vld_q <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            m0_rsp_vld_q <= rsp0_d;
            m1_rsp_vld_q <= rsp1_d;
            if (load0_d) m0_rdata_q <= mem_rdata;
            if (load1_d) m1_rdata_q <= mem_rdata;
        end
    end

    assign m0_rsp_vld = m0_rsp_vld_q;
    assign m1_rsp_vld = m1_rsp_vld_q;
    assign m0_rdata   = m0_rdata_q;
    assign m1_rdata   = m1_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural word memory.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [11:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic [3:0]  m0_be = '0, m1_be = '0;
    logic        m0_gnt, m0_rsp_vld, m1_gnt, m1_rsp_vld;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_wen, mem_ren;
    logic [11:0] mem_waddr, mem_raddr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] tbmem [0:1023];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_gnt(m0_gnt), .m0_rsp_vld(m0_rsp_vld), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_gnt(m1_gnt), .m1_rsp_vld(m1_rsp_vld), .m1_rdata(m1_rdata),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    // Word-addressed memory: combinational read, clocked write
    assign mem_rdata = tbmem[mem_raddr[11:2]];
    always @(posedge clk) if (mem_wen) tbmem[mem_waddr[11:2]] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("check %-14s obs=%08h exp=%08h ok", tag, obs, exp);
        end else begin
            $display("FAIL %-14s obs=%08h exp=%08h", tag, obs, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic req, input logic we, input logic [11:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
        m0_req = req; m0_we = we; m0_addr = a; m0_wdata = wd; m0_be = be;
    endtask

    task automatic drv1(input logic req, input logic we, input logic [11:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
        m1_req = req; m1_we = we; m1_addr = a; m1_wdata = wd; m1_be = be;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) tbmem[i] <= 32'h0;
        tbmem[4] <= 32'hCAFEF00D;   // byte addr 0x10
        tbmem[2] <= 32'h11223344;   // byte addr 0x08
        tbmem[3] <= 32'h55667788;   // byte addr 0x0C
        #1;

        // ---- reset values ----
        step(); step();
        chk("rst_rsp0", {31'd0, m0_rsp_vld}, 32'd0);
        chk("rst_rsp1", {31'd0, m1_rsp_vld}, 32'd0);
        chk("rst_rdata0", m0_rdata, 32'd0);
        chk("rst_rdata1", m1_rdata, 32'd0);
        chk("rst_wen", {31'd0, mem_wen}, 32'd0);
        chk("rst_ren", {31'd0, mem_ren}, 32'd0);
        chk("rst_waddr", {20'd0, mem_waddr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        step();

        // ---- 1: reset in the RMW cycle abandons the store ----
        drv0(1, 1, 12'h010, 32'h000000AA, 4'h1);
        #1;
        chk("t1_gnt0", {31'd0, m0_gnt}, 32'd1);
        chk("t1_ren", {31'd0, mem_ren}, 32'd1);
        chk("t1_wen_grant", {31'd0, mem_wen}, 32'd0);
        step();
        drv0(0, 0, 12'h000, 32'h0, 4'h0);
        #1;
        chk("t1_wen_rmw", {31'd0, mem_wen}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t1_wen_inrst", {31'd0, mem_wen}, 32'd0);
        step();
        chk("t1_rsp0", {31'd0, m0_rsp_vld}, 32'd0);
        chk("t1_mem", tbmem[4], 32'hCAFEF00D);
        rst = 1'b0;
        drv0(1, 0, 12'h010, 32'h0, 4'h0);
        #1;
        chk("t1_rb_gnt", {31'd0, m0_gnt}, 32'd1);
        step();
        drv0(0, 0, 12'h000, 32'h0, 4'h0);
        chk("t1_rb_vld", {31'd0, m0_rsp_vld}, 32'd1);
        chk("t1_rb_data", m0_rdata, 32'hCAFEF00D);

        // ---- 2: full-word store then load ----
        drv0(1, 1, 12'h004, 32'hDEADBEEF, 4'hF);
        #1;
        chk("t2_gnt0", {31'd0, m0_gnt}, 32'd1);
        chk("t2_wen", {31'd0, mem_wen}, 32'd1);
        chk("t2_ren", {31'd0, mem_ren}, 32'd0);
        chk("t2_waddr", {20'd0, mem_waddr}, 32'h004);
        chk("t2_wdata", mem_wdata, 32'hDEADBEEF);
        step();
        chk("t2_st_vld", {31'd0, m0_rsp_vld}, 32'd1);
        chk("t2_st_rdata", m0_rdata, 32'hCAFEF00D);
        chk("t2_mem", tbmem[1], 32'hDEADBEEF);
        drv0(1, 0, 12'h004, 32'h0, 4'h0);
        #1;
        chk("t2_ld_gnt", {31'd0, m0_gnt}, 32'd1);
        step();
        drv0(0, 0, 12'h000, 32'h0, 4'h0);
        chk("t2_ld_vld", {31'd0, m0_rsp_vld}, 32'd1);
        chk("t2_ld_data", m0_rdata, 32'hDEADBEEF);

        // ---- 3: partial store via RMW from M1 ----
        drv1(1, 1, 12'h008, 32'hAABBCCDD, 4'b0101);
        #1;
        chk("t3_gnt1", {31'd0, m1_gnt}, 32'd1);
        chk("t3_ren", {31'd0, mem_ren}, 32'd1);
        chk("t3_raddr", {20'd0, mem_raddr}, 32'h008);
        chk("t3_wen_grant", {31'd0, mem_wen}, 32'd0);
        step();
        drv1(0, 0, 12'h000, 32'h0, 4'h0);
        #1;
        chk("t3_rmw_wen", {31'd0, mem_wen}, 32'd1);
        chk("t3_rmw_ren", {31'd0, mem_ren}, 32'd0);
        chk("t3_rmw_waddr", {20'd0, mem_waddr}, 32'h008);
        chk("t3_rmw_wdata", mem_wdata, 32'h11BB33DD);
        chk("t3_rmw_vld", {31'd0, m1_rsp_vld}, 32'd0);
        step();
        chk("t3_vld1", {31'd0, m1_rsp_vld}, 32'd1);
        chk("t3_vld0", {31'd0, m0_rsp_vld}, 32'd0);
        chk("t3_mem", tbmem[2], 32'h11BB33DD);

        // ---- 4: round-robin from reset, both loading continuously ----
        rst = 1'b1;
        step();
        rst = 1'b0;
        drv0(1, 0, 12'h004, 32'h0, 4'h0);
        drv1(1, 0, 12'h008, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("t4_gnt0_%0d", k), {31'd0, m0_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("t4_gnt1_%0d", k), {31'd0, m1_gnt}, (k % 2 == 1) ? 32'd1 : 32'd0);
            step();
            chk($sformatf("t4_vld0_%0d", k), {31'd0, m0_rsp_vld}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("t4_vld1_%0d", k), {31'd0, m1_rsp_vld}, (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k % 2 == 0) chk($sformatf("t4_data0_%0d", k), m0_rdata, 32'hDEADBEEF);
            else            chk($sformatf("t4_data1_%0d", k), m1_rdata, 32'h11BB33DD);
        end
        drv0(0, 0, 12'h000, 32'h0, 4'h0);
        drv1(0, 0, 12'h000, 32'h0, 4'h0);
        step();

        // ---- 5: M1 load waits out an M0 RMW and sees the merged word ----
        drv0(1, 1, 12'h00C, 32'h0000AA00, 4'b0010);
        drv1(1, 0, 12'h00C, 32'h0, 4'h0);
        #1;
        chk("t5_gnt0", {31'd0, m0_gnt}, 32'd1);
        chk("t5_gnt1_arb", {31'd0, m1_gnt}, 32'd0);
        step();
        drv0(0, 0, 12'h000, 32'h0, 4'h0);
        #1;
        chk("t5_gnt1_rmw", {31'd0, m1_gnt}, 32'd0);
        chk("t5_rmw_wen", {31'd0, mem_wen}, 32'd1);
        chk("t5_rmw_ren", {31'd0, mem_ren}, 32'd0);
        step();
        chk("t5_vld0", {31'd0, m0_rsp_vld}, 32'd1);
        chk("t5_gnt1_after", {31'd0, m1_gnt}, 32'd1);
        step();
        drv1(0, 0, 12'h000, 32'h0, 4'h0);
        chk("t5_vld1", {31'd0, m1_rsp_vld}, 32'd1);
        chk("t5_vld0_quiet", {31'd0, m0_rsp_vld}, 32'd0);
        chk("t5_data1", m1_rdata, 32'h5566AA88);

        // ---- 6: be=0 store, then unaligned load ----
        drv0(1, 1, 12'h008, 32'hFFFFFFFF, 4'h0);
        #1;
        chk("t6_gnt0", {31'd0, m0_gnt}, 32'd1);
        chk("t6_wen", {31'd0, mem_wen}, 32'd0);
        chk("t6_ren", {31'd0, mem_ren}, 32'd0);
        step();
        drv0(0, 0, 12'h000, 32'h0, 4'h0);
        chk("t6_vld0", {31'd0, m0_rsp_vld}, 32'd1);
        chk("t6_mem", tbmem[2], 32'h11BB33DD);
        drv1(1, 0, 12'h00B, 32'h0, 4'h0);
        #1;
        chk("t6_gnt1", {31'd0, m1_gnt}, 32'd1);
        chk("t6_raddr", {20'd0, mem_raddr}, 32'h00B);
        step();
        drv1(0, 0, 12'h000, 32'h0, 4'h0);
        chk("t6_vld1", {31'd0, m1_rsp_vld}, 32'd1);
        chk("t6_data1", m1_rdata, 32'h11BB33DD);

        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
